store_buffer: RTL and testbench
===============================

# store_buffer

Posted-write buffer between the core's memory stage and the data-memory write port. Accepts one store per cycle from the M stage, queues up to DEPTH word-aligned entries, and retires them through a valid/ready bus so a slow or arbitrated write port never stalls the pipeline unless the buffer is full. Loads read memory directly through a combinational pass-through port. The buffer stalls a load that hits a pending store's word, guaranteeing read-after-write ordering.

## Interface
- DEPTH, 4, number of entries; power of two, ≥2
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low; clears all state
- MemWriteM  in  1  store request from M stage
- MemReadM  in  1  load request from M stage
- ALUResultM  in  32  byte address of load/store
- WriteDataM  in  32  store data, already lane-aligned
- byteEnable  in  4  store byte lanes
- StallMem  out  1  to hazard unit; holds F/D/E/M while high
- BufEmpty  out  1  no pending entries (for fence/drain)
- mem_raddr  out  32  load address to memory read port (= ALUResultM)
- bus_valid  out  1  head entry presented
- bus_addr  out  32  {head word, 2'b00}
- bus_wdata  out  32  head data
- bus_be  out  4  head byte enables
- bus_ready  in  1  write port accepts head this cycle

## Operation
- Entry = {word[29:0] = addr[31:2], data[31:0], be[3:0]}; circular array, head/tail pointers, count 0..DEPTH.
- Dequeue: bus_valid && bus_ready → head advances, count−1.
- Coalesce: MemWriteM, count ≥ 2, newest entry word == ALUResultM[31:2] → merge into newest entry: lanes with byteEnable set take WriteDataM bytes, be |= byteEnable; count unchanged. The head entry is never merged because it may be on the bus.
- Enqueue: MemWriteM, no coalesce, count < DEPTH → write at tail, tail+1, count+1.
- Full store: MemWriteM, no coalesce, count == DEPTH → StallMem=1, nothing written. Same-cycle dequeue does not free a slot for that cycle.
- Load hazard: MemReadM and any valid entry word == ALUResultM[31:2] → StallMem=1. The match is word-granular and conservative. It clears the cycle after the last matching entry dequeues.
- StallMem = full-store stall OR load hazard. The core holds its M-stage inputs stable while stalled.
- If MemReadM and MemWriteM are both high, both conditions are evaluated independently.
- Stores with byteEnable == 0 are dropped: no enqueue and no stall.
- Simultaneous enqueue + dequeue: count unchanged, both pointers advance.
- Pointers wrap modulo DEPTH. count distinguishes full from empty.

## Timing
- Reset values: count=0, pointers=0, bus_valid=0, bus_addr=0, bus_wdata=0, bus_be=0, BufEmpty=1, StallMem=0 (inputs low).
- bus_* outputs are driven from registers only (head entry, count ≠ 0); no combinational path from any input to bus_*.
- Enqueue into an empty buffer → bus_valid=1 on the next cycle, so minimum store-to-bus latency is 1 cycle.
- Payload stays stable while bus_valid && !bus_ready; bus_valid never drops without a handshake, except on reset.
- StallMem is combinational from MemWriteM/MemReadM/ALUResultM/byteEnable and registered state; it has no bus_ready dependency.
- mem_raddr is a combinational pass-through.
- Reset asserted mid-operation discards pending entries; bus_valid falls asynchronously.
- Sustained throughput is 1 store/cycle when bus_ready is held high.

## Structure
- riscv_pkg: sb_entry_t struct (word, data, be) and the SB_WORD_W = 30 constant.
- Sub-module sb_addr_match: parallel word comparator over the valid entries, returning any-hit (load hazard).
- Storage, pointers and merge logic stay inline.

## Test plan
- Single store, addr 0x100, data 0xDEADBEEF, be 0xF, bus_ready=1 → next cycle bus_valid=1, bus_addr=0x100, bus_wdata=0xDEADBEEF; the cycle after, BufEmpty=1.
- bus_ready=0, five stores to distinct words 0x0/0x4/0x8/0xC/0x10 (DEPTH=4) → first four enqueue; fifth sees StallMem=1. Raise bus_ready → fifth enqueues one cycle after the first dequeue; bus order 0x0,0x4,0x8,0xC,0x10.
- bus_ready=0; stores 0x200 then 0x300 be=0x1 data 0x000000AA, then 0x300 be=0x2 data 0x0000BB00 → count stays 2. Drained 0x300 entry has be=0x3, wdata[15:0]=0xBBAA.
- Pending store to 0x404, then load 0x406 → StallMem=1 until the entry dequeues, then 0. A load to 0x408 in the same state → StallMem=0.
- bus_valid=1 held with bus_ready=0 for 5 cycles → bus_addr/bus_wdata/bus_be unchanged each cycle.
- Three entries pending, reset pulsed low mid-cycle → bus_valid=0 immediately, BufEmpty=1. After release, a new store appears on the bus alone.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared types for the store buffer: one queued store entry and its word width.
package riscv_pkg;

  localparam int SB_WORD_W = 30;

  typedef struct packed {
    logic [SB_WORD_W-1:0] word;
    logic [31:0]          data;
    logic [3:0]           be;
  } sb_entry_t;

endpackage

// File: rtl/sb_addr_match.sv
// Parallel word comparator over the valid store-buffer entries; flags any hit.
module sb_addr_match
  import riscv_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic [DEPTH*SB_WORD_W-1:0] words,
  input  logic [DEPTH-1:0]           valid,
  input  logic [SB_WORD_W-1:0]       addr_word,
  output logic                       hit
);

  // OR together the per-entry equality results of every valid entry
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i] && (words[i*SB_WORD_W +: SB_WORD_W] == addr_word)) begin
        hit = 1'b1;
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Posted-write store buffer: queues word-aligned stores from the M stage,
// merges same-word stores into the newest entry, retires the head through a
// valid/ready write bus and stalls loads that hit a pending store's word.
module store_buffer
  import riscv_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWriteM,
  input  logic        MemReadM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic [3:0]  byteEnable,
  output logic        StallMem,
  output logic        BufEmpty,
  output logic [31:0] mem_raddr,
  output logic        bus_valid,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_ready
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_TWO  = CNT_W'(2);

  sb_entry_t              entries_q [DEPTH];
  sb_entry_t              entries_d [DEPTH];
  logic [PTR_W-1:0]       head_q, head_d;
  logic [PTR_W-1:0]       tail_q, tail_d;
  logic [CNT_W-1:0]       count_q, count_d;

  logic [PTR_W-1:0]       newest_idx;
  logic                   store_req;
  logic                   coalesce;
  logic                   enq;
  logic                   deq;
  logic                   full_stall;
  logic                   load_hit;
  logic [DEPTH*SB_WORD_W-1:0] words_flat;
  logic [DEPTH-1:0]       valid_mask;
  logic [PTR_W-1:0]       offset;

  assign mem_raddr  = ALUResultM;
  assign newest_idx = tail_q - PTR_W'(1);

  // Head is on the bus whenever the buffer holds anything; payload is zero when empty
  always_comb begin
    bus_valid = (count_q != '0);
    BufEmpty  = (count_q == '0);
    bus_addr  = '0;
    bus_wdata = '0;
    bus_be    = '0;
    if (bus_valid) begin
      bus_addr  = {entries_q[head_q].word, 2'b00};
      bus_wdata = entries_q[head_q].data;
      bus_be    = entries_q[head_q].be;
    end
  end

  // Classify this cycle's store and bus handshake; never merge into the head
  always_comb begin
    store_req  = MemWriteM && (byteEnable != 4'b0000);
    coalesce   = store_req && (count_q >= CNT_TWO) &&
                 (entries_q[newest_idx].word == ALUResultM[31:2]);
    enq        = store_req && !coalesce && (count_q < CNT_FULL);
    full_stall = store_req && !coalesce && (count_q == CNT_FULL);
    deq        = bus_valid && bus_ready;
  end

  // Build the word vector and occupancy mask for the load-hazard comparator
  always_comb begin
    words_flat = '0;
    valid_mask = '0;
    offset     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      words_flat[i*SB_WORD_W +: SB_WORD_W] = entries_q[i].word;
      offset        = PTR_W'(i) - head_q;
      valid_mask[i] = ({1'b0, offset} < count_q);
    end
  end

  sb_addr_match #(
    .DEPTH (DEPTH)
  ) u_addr_match (
    .words     (words_flat),
    .valid     (valid_mask),
    .addr_word (ALUResultM[31:2]),
    .hit       (load_hit)
  );

  assign StallMem = full_stall || (MemReadM && load_hit);

  // Next-state for storage, pointers and occupancy count
  always_comb begin
    entries_d = entries_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    if (deq) begin
      head_d = head_q + PTR_W'(1);
    end
    if (coalesce) begin
      for (int b = 0; b < 4; b++) begin
        if (byteEnable[b]) begin
          entries_d[newest_idx].data[b*8 +: 8] = WriteDataM[b*8 +: 8];
        end
      end
      entries_d[newest_idx].be = entries_q[newest_idx].be | byteEnable;
    end else if (enq) begin
      entries_d[tail_q].word = ALUResultM[31:2];
      entries_d[tail_q].data = WriteDataM;
      entries_d[tail_q].be   = byteEnable;
      tail_d = tail_q + PTR_W'(1);
    end
    case ({enq, deq})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state: pointers and count, cleared asynchronously
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry payload storage; validity comes from the pointers and count
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      entries_q[i] <= entries_d[i];
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: a table of per-cycle vectors plus
// hand-written sequences for payload hold and asynchronous reset.
module tb_store_buffer;

  logic        clk;
  logic        reset;
  logic        MemWriteM;
  logic        MemReadM;
  logic [31:0] ALUResultM;
  logic [31:0] WriteDataM;
  logic [3:0]  byteEnable;
  logic        StallMem;
  logic        BufEmpty;
  logic [31:0] mem_raddr;
  logic        bus_valid;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ready;

  int n_cmp;
  int n_bad;

  store_buffer #(.DEPTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .MemWriteM  (MemWriteM),
    .MemReadM   (MemReadM),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .byteEnable (byteEnable),
    .StallMem   (StallMem),
    .BufEmpty   (BufEmpty),
    .mem_raddr  (mem_raddr),
    .bus_valid  (bus_valid),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_be     (bus_be),
    .bus_ready  (bus_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        w;
    logic        r;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        rdy;
    logic        e_stall;
    logic        e_empty;
    logic        e_valid;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic [3:0]  e_be;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic w, logic r, logic [31:0] addr, logic [31:0] wdata,
                              logic [3:0] be, logic rdy, logic e_stall, logic e_empty,
                              logic e_valid, logic [31:0] e_addr, logic [31:0] e_wdata,
                              logic [3:0] e_be);
    vec_t v;
    v.w = w; v.r = r; v.addr = addr; v.wdata = wdata; v.be = be; v.rdy = rdy;
    v.e_stall = e_stall; v.e_empty = e_empty; v.e_valid = e_valid;
    v.e_addr = e_addr; v.e_wdata = e_wdata; v.e_be = e_be;
    return v;
  endfunction

  task automatic drive(logic w, logic r, logic [31:0] addr, logic [31:0] wdata,
                       logic [3:0] be, logic rdy);
    MemWriteM  = w;
    MemReadM   = r;
    ALUResultM = addr;
    WriteDataM = wdata;
    byteEnable = be;
    bus_ready  = rdy;
  endtask

  task automatic check(string name, logic [70:0] act, logic [70:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got {stall,empty,valid,addr,wdata,be}=%h, expected %h", name, act, exp);
    end
  endtask

  task automatic check1(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [70:0] outs();
    return {StallMem, BufEmpty, bus_valid, bus_addr, bus_wdata, bus_be};
  endfunction

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);

    // w r addr wdata be rdy | stall empty valid bus_addr bus_wdata bus_be (state before the edge)
    vecs.push_back(mk(0,0,32'h0,  32'h0,        4'h0,0, 0,1,0,32'h0,  32'h0,        4'h0));
    vecs.push_back(mk(1,0,32'h100,32'hDEADBEEF, 4'hF,1, 0,1,0,32'h0,  32'h0,        4'h0));
    vecs.push_back(mk(0,0,32'h0,  32'h0,        4'h0,1, 0,0,1,32'h100,32'hDEADBEEF, 4'hF));
    vecs.push_back(mk(0,0,32'h0,  32'h0,        4'h0,0, 0,1,0,32'h0,  32'h0,        4'h0));
    vecs.push_back(mk(1,0,32'h0,  32'h11111111, 4'hF,0, 0,1,0,32'h0,  32'h0,        4'h0));
    vecs.push_back(mk(1,0,32'h4,  32'h22222222, 4'hF,0, 0,0,1,32'h0,  32'h11111111, 4'hF));
    vecs.push_back(mk(1,0,32'h8,  32'h33333333, 4'hF,0, 0,0,1,32'h0,  32'h11111111, 4'hF));
    vecs.push_back(mk(1,0,32'hC,  32'h44444444, 4'hF,0, 0,0,1,32'h0,  32'h11111111, 4'hF));
    vecs.push_back(mk(1,0,32'h10, 32'h55555555, 4'hF,0, 1,0,1,32'h0,  32'h11111111, 4'hF));
    vecs.push_back(mk(1,0,32'h10, 32'h55555555, 4'hF,1, 1,0,1,32'h0,  32'h11111111, 4'hF));
    vecs.push_back(mk(1,0,32'h10, 32'h55555555, 4'hF,0, 0,0,1,32'h4,  32'h22222222, 4'hF));
    vecs.push_back(mk(0,0,32'h0,  32'h0,        4'h0,1, 0,0,1,32'h4,  32'h22222222, 4'hF));
    vecs.push_back(mk(0,0,32'h0,  32'h0,        4'h0,1, 0,0,1,32'h8,  32'h33333333, 4'hF));
    vecs.push_back(mk(0,0,32'h0,  32'h0,        4'h0,1, 0,0,1,32'hC,  32'h44444444, 4'hF));
    vecs.push_back(mk(0,0,32'h0,  32'h0,        4'h0,1, 0,0,1,32'h10, 32'h55555555, 4'hF));
    vecs.push_back(mk(0,0,32'h0,  32'h0,        4'h0,0, 0,1,0,32'h0,  32'h0,        4'h0));
    vecs.push_back(mk(1,0,32'h200,32'h12345678, 4'hF,0, 0,1,0,32'h0,  32'h0,        4'h0));
    vecs.push_back(mk(1,0,32'h300,32'h000000AA, 4'h1,0, 0,0,1,32'h200,32'h12345678, 4'hF));
    vecs.push_back(mk(1,0,32'h300,32'h0000BB00, 4'h2,0, 0,0,1,32'h200,32'h12345678, 4'hF));
    vecs.push_back(mk(0,1,32'h302,32'h0,        4'h0,0, 1,0,1,32'h200,32'h12345678, 4'hF));
    vecs.push_back(mk(0,1,32'h304,32'h0,        4'h0,0, 0,0,1,32'h200,32'h12345678, 4'hF));
    vecs.push_back(mk(0,0,32'h0,  32'h0,        4'h0,1, 0,0,1,32'h200,32'h12345678, 4'hF));
    vecs.push_back(mk(0,1,32'h300,32'h0,        4'h0,1, 1,0,1,32'h300,32'h0000BBAA, 4'h3));
    vecs.push_back(mk(0,1,32'h300,32'h0,        4'h0,0, 0,1,0,32'h0,  32'h0,        4'h0));
    vecs.push_back(mk(1,0,32'h404,32'hCAFEF00D, 4'hF,0, 0,1,0,32'h0,  32'h0,        4'h0));
    vecs.push_back(mk(0,1,32'h406,32'h0,        4'h0,0, 1,0,1,32'h404,32'hCAFEF00D, 4'hF));
    vecs.push_back(mk(0,1,32'h408,32'h0,        4'h0,0, 0,0,1,32'h404,32'hCAFEF00D, 4'hF));
    vecs.push_back(mk(0,1,32'h406,32'h0,        4'h0,1, 1,0,1,32'h404,32'hCAFEF00D, 4'hF));
    vecs.push_back(mk(0,1,32'h406,32'h0,        4'h0,0, 0,1,0,32'h0,  32'h0,        4'h0));
    vecs.push_back(mk(1,0,32'h500,32'h99999999, 4'h0,0, 0,1,0,32'h0,  32'h0,        4'h0));
    vecs.push_back(mk(0,0,32'h0,  32'h0,        4'h0,0, 0,1,0,32'h0,  32'h0,        4'h0));
    vecs.push_back(mk(1,0,32'h600,32'h00000060, 4'hF,1, 0,1,0,32'h0,  32'h0,        4'h0));
    vecs.push_back(mk(1,0,32'h604,32'h00000061, 4'hF,1, 0,0,1,32'h600,32'h00000060, 4'hF));
    vecs.push_back(mk(1,0,32'h608,32'h00000062, 4'hF,1, 0,0,1,32'h604,32'h00000061, 4'hF));
    vecs.push_back(mk(0,0,32'h0,  32'h0,        4'h0,1, 0,0,1,32'h608,32'h00000062, 4'hF));
    vecs.push_back(mk(0,0,32'h0,  32'h0,        4'h0,0, 0,1,0,32'h0,  32'h0,        4'h0));

    repeat (2) @(negedge clk);
    #2;
    check("reset_state", outs(), {1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0});
    reset = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].w, vecs[i].r, vecs[i].addr, vecs[i].wdata, vecs[i].be, vecs[i].rdy);
      #2;
      check($sformatf("vec[%0d]", i), outs(),
            {vecs[i].e_stall, vecs[i].e_empty, vecs[i].e_valid,
             vecs[i].e_addr, vecs[i].e_wdata, vecs[i].e_be});
      if (vecs[i].r) check1($sformatf("raddr[%0d]", i), mem_raddr, vecs[i].addr);
    end

    // Three entries pending with the bus stalled; head payload must hold
    @(negedge clk); drive(1'b1, 1'b0, 32'h800, 32'hA0A0A0A0, 4'hF, 1'b0);
    @(negedge clk); drive(1'b1, 1'b0, 32'h810, 32'hB1B1B1B1, 4'h3, 1'b0);
    @(negedge clk); drive(1'b1, 1'b0, 32'h820, 32'hC2C2C2C2, 4'hF, 1'b0);
    @(negedge clk); drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      #2;
      check($sformatf("hold[%0d]", k), outs(), {1'b0, 1'b0, 1'b1, 32'h800, 32'hA0A0A0A0, 4'hF});
      @(negedge clk);
    end

    // Reset pulsed mid-cycle discards everything immediately
    #2;
    reset = 1'b0;
    #1;
    check("async_reset", outs(), {1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0});
    @(negedge clk);
    reset = 1'b1;
    drive(1'b1, 1'b0, 32'h700, 32'h77777777, 4'hF, 1'b0);
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
    #2;
    check("post_reset_store", outs(), {1'b0, 1'b0, 1'b1, 32'h700, 32'h77777777, 4'hF});
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    #2;
    check("post_reset_alone", outs(), {1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
